// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arbiter_pkg;

  localparam int unsigned AddrW = 8;
  localparam int unsigned DataW = 16;

  typedef logic [AddrW-1:0] addr_t;
  typedef logic [DataW-1:0] data_t;

  typedef enum logic [1:0] {
    StIdle,
    StHIssue,
    StHData,
    StRestore
  } arb_state_e;

  typedef enum logic [1:0] {
    OwnerCpu     = 2'd0,
    OwnerHost    = 2'd1,
    OwnerRestore = 2'd2
  } owner_e;

  // Host command captured at grant.
  typedef struct packed {
    logic  wr;
    addr_t addr;
    data_t wdata;
  } host_cmd_t;

  function automatic owner_e state_owner(arb_state_e st);
    owner_e own;
    unique case (st)
      StHIssue, StHData: own = OwnerHost;
      StRestore:         own = OwnerRestore;
      default:           own = OwnerCpu;
    endcase
    return own;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// CPU, host and RAM signal bundle around the data-memory arbiter.
interface dmem_arbiter_if;
  import dmem_arbiter_pkg::*;

  // CPU control path side
  logic       cpu_req;
  logic       cpu_wr;
  addr_t      cpu_addr;
  data_t      cpu_wdata;
  logic       cpu_hold;
  // Host port side
  logic       host_req;
  logic       host_wr;
  addr_t      host_addr;
  data_t      host_wdata;
  logic       host_ack;
  data_t      host_rdata;
  // RAM side
  addr_t      mem_addr;
  logic       mem_wr;
  data_t      mem_wdata;
  data_t      mem_rdata;
  // Debug
  logic [1:0] owner;

  // Environment view: drives requests and RAM read data.
  modport master (
    output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_hold,
    output host_req, host_wr, host_addr, host_wdata,
    input  host_ack, host_rdata,
    input  mem_addr, mem_wr, mem_wdata,
    output mem_rdata,
    input  owner
  );

  // Arbiter view.
  modport slave (
    input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_hold,
    input  host_req, host_wr, host_addr, host_wdata,
    output host_ack, host_rdata,
    output mem_addr, mem_wr, mem_wdata,
    input  mem_rdata,
    output owner
  );

endinterface

// File: rtl/dmem_arbiter_wait_ctr.sv
// Saturating starvation counter: counts CPU-won cycles while the host waits.
module dmem_arbiter_wait_ctr #(
  parameter int unsigned MaxWait = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic inc_i,
  input  logic clr_i,
  output logic hit_o
);

  localparam int unsigned CntW = (MaxWait > 1) ? $clog2(MaxWait) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(MaxWait - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign hit_o = (cnt_q == CntMax);

  // Next count: clear wins, increment stops at the hit value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !hit_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register, synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data RAM arbiter: CPU has priority, host is served on idle
// cycles or forced in after MaxWait contended cycles by freezing the CPU.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned MaxWait = 4
) (
  input logic           Clk,
  input logic           Reset,
  dmem_arbiter_if.slave bus_io
);

  arb_state_e state_q, state_d;
  host_cmd_t  cmd_q, cmd_d;
  logic       ack_q, ack_d;
  data_t      rdata_q, rdata_d;

  logic       host_req_eff;
  logic       wait_hit;
  logic       grant;
  logic       wait_inc;
  logic       wait_clr;

  // Requests seen during the ack cycle belong to the finishing transaction.
  assign host_req_eff = bus_io.host_req & ~ack_q;
  assign grant        = (state_q == StIdle) & host_req_eff & (~bus_io.cpu_req | wait_hit);
  assign wait_inc     = (state_q == StIdle) & host_req_eff & bus_io.cpu_req;
  assign wait_clr     = grant | ~bus_io.host_req;

  dmem_arbiter_wait_ctr #(
    .MaxWait (MaxWait)
  ) u_wait_ctr (
    .Clk   (Clk),
    .Reset (Reset),
    .inc_i (wait_inc),
    .clr_i (wait_clr),
    .hit_o (wait_hit)
  );

  assign bus_io.host_ack   = ack_q;
  assign bus_io.host_rdata = rdata_q;
  assign bus_io.owner      = state_owner(state_q);

  // Next-state, host capture and RAM steering.
  always_comb begin
    state_d          = state_q;
    cmd_d            = cmd_q;
    ack_d            = 1'b0;
    rdata_d          = rdata_q;
    bus_io.mem_addr  = bus_io.cpu_addr;
    bus_io.mem_wr    = bus_io.cpu_wr;
    bus_io.mem_wdata = bus_io.cpu_wdata;
    bus_io.cpu_hold  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (grant) begin
          cmd_d.wr    = bus_io.host_wr;
          cmd_d.addr  = bus_io.host_addr;
          cmd_d.wdata = bus_io.host_wdata;
          state_d     = StHIssue;
        end
      end
      StHIssue: begin
        bus_io.mem_addr  = cmd_q.addr;
        bus_io.mem_wr    = cmd_q.wr;
        bus_io.mem_wdata = cmd_q.wdata;
        bus_io.cpu_hold  = 1'b1;
        state_d          = StHData;
      end
      StHData: begin
        bus_io.mem_addr  = cmd_q.addr;
        bus_io.mem_wr    = 1'b0;
        bus_io.mem_wdata = cmd_q.wdata;
        bus_io.cpu_hold  = 1'b1;
        if (!cmd_q.wr) begin
          rdata_d = bus_io.mem_rdata;
        end
        ack_d   = 1'b1;
        state_d = bus_io.cpu_req ? StRestore : StIdle;
      end
      StRestore: begin
        // Re-present the CPU address so a frozen load sees its data after release.
        bus_io.mem_addr = bus_io.cpu_addr;
        bus_io.mem_wr   = 1'b0;
        bus_io.cpu_hold = 1'b1;
        state_d         = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and host-side registers, synchronous reset drops any in-flight transaction.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
      cmd_q   <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios then randomized host/CPU traffic.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int unsigned MaxWait = 4;

  logic Clk = 1'b0;
  logic Reset = 1'b1;

  dmem_arbiter_if bus ();

  dmem_arbiter #(
    .MaxWait (MaxWait)
  ) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .bus_io (bus.slave)
  );

  always #5 Clk = ~Clk;

  // Synchronous RAM, one-cycle read latency.
  data_t ram [256];
  always @(posedge Clk) begin
    if (bus.mem_wr === 1'b1) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  int ack_cnt = 0;
  always @(posedge Clk) begin
    if (bus.host_ack === 1'b1) ack_cnt <= ack_cnt + 1;
  end

  int    checks = 0;
  int    failures = 0;
  data_t shadow [256];
  data_t last_rdata = '0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic idle_inputs();
    bus.cpu_req    = 1'b0;
    bus.cpu_wr     = 1'b0;
    bus.cpu_wdata  = '0;
    bus.host_req   = 1'b0;
    bus.host_wr    = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
  endtask

  task automatic cpu_store(addr_t a, data_t d);
    bus.cpu_req   = 1'b1;
    bus.cpu_wr    = 1'b1;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    tick();
    bus.cpu_req = 1'b0;
    bus.cpu_wr  = 1'b0;
    shadow[a]   = d;
  endtask

  // One host transaction with the CPU either idle or continuously requesting.
  task automatic host_xact(logic cpu, logic cwr, addr_t caddr, data_t cwd,
                           logic hwr, addr_t haddr, data_t hwd);
    int exp_lat;
    int exp_hold;
    int lat;
    int holds;
    // CPU is served before the host slot; the host access follows.
    if (cpu && cwr) shadow[caddr] = cwd;
    if (hwr) shadow[haddr] = hwd;
    else     last_rdata = shadow[haddr];
    exp_lat  = cpu ? int'(MaxWait) - 1 + 3 : 3;
    exp_hold = cpu ? 3 : 2;

    bus.cpu_req    = cpu;
    bus.cpu_wr     = cpu & cwr;
    bus.cpu_addr   = caddr;
    bus.cpu_wdata  = cwd;
    bus.host_req   = 1'b1;
    bus.host_wr    = hwr;
    bus.host_addr  = haddr;
    bus.host_wdata = hwd;
    lat   = -1;
    holds = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (bus.cpu_hold === 1'b1) begin
        holds++;
        // Frozen CPU outputs are garbage; none of it may reach RAM.
        bus.cpu_wdata = ~cwd;
      end
      if (bus.host_ack === 1'b1) begin
        lat = c;
        break;
      end
      tick();
    end
    chk("rnd_latency", lat, exp_lat);
    chk("rnd_hold_cycles", holds, exp_hold);
    chk("rnd_host_rdata", bus.host_rdata, last_rdata);
    idle_inputs();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int base;
    int mism;
    idle_inputs();
    bus.cpu_addr = 8'h10;
    Reset = 1'b1;
    repeat (2) tick();
    Reset = 1'b0;

    // Reset state and idle pass-through
    #1;
    chk("rst_mem_addr", bus.mem_addr, 8'h10);
    chk("rst_cpu_hold", bus.cpu_hold, 1'b0);
    chk("rst_host_ack", bus.host_ack, 1'b0);
    chk("rst_owner", bus.owner, 2'd0);
    chk("rst_host_rdata", bus.host_rdata, 16'h0);

    for (int i = 0; i < 256; i++) cpu_store(addr_t'(i), '0);

    // Host write then read back, CPU idle
    base = ack_cnt;
    bus.host_req = 1'b1; bus.host_wr = 1'b1; bus.host_addr = 8'h2A; bus.host_wdata = 16'hBEEF;
    #1;
    chk("hw_idle_owner", bus.owner, 2'd0);
    tick(); #1;
    chk("hw_issue_mem_wr", bus.mem_wr, 1'b1);
    chk("hw_issue_mem_addr", bus.mem_addr, 8'h2A);
    chk("hw_issue_mem_wdata", bus.mem_wdata, 16'hBEEF);
    chk("hw_issue_hold", bus.cpu_hold, 1'b1);
    chk("hw_issue_owner", bus.owner, 2'd1);
    tick(); #1;
    chk("hw_data_mem_wr", bus.mem_wr, 1'b0);
    chk("hw_data_ack", bus.host_ack, 1'b0);
    tick(); #1;
    chk("hw_ack", bus.host_ack, 1'b1);
    idle_inputs();
    tick(); #1;
    chk("hw_ack_pulse", bus.host_ack, 1'b0);
    chk("hw_ram", ram[8'h2A], 16'hBEEF);
    shadow[8'h2A] = 16'hBEEF;
    bus.host_req = 1'b1; bus.host_wr = 1'b0; bus.host_addr = 8'h2A;
    tick(); tick(); tick(); #1;
    chk("hr_ack", bus.host_ack, 1'b1);
    chk("hr_rdata", bus.host_rdata, 16'hBEEF);
    idle_inputs();
    tick(); tick(); #1;
    chk("hr_ack_count", ack_cnt - base, 2);
    chk("hr_ack_low", bus.host_ack, 1'b0);
    last_rdata = 16'hBEEF;

    // CPU load pass-through
    cpu_store(8'h10, 16'h1234);
    bus.cpu_req = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_addr = 8'h10;
    #1;
    chk("cl_mem_addr", bus.mem_addr, 8'h10);
    chk("cl_mem_wr", bus.mem_wr, 1'b0);
    chk("cl_hold0", bus.cpu_hold, 1'b0);
    tick(); #1;
    chk("cl_rdata", bus.mem_rdata, 16'h1234);
    chk("cl_hold1", bus.cpu_hold, 1'b0);
    bus.cpu_req = 1'b0;
    tick();

    // Contended host read: forced in after MaxWait CPU cycles
    cpu_store(8'h05, 16'h5555);
    cpu_store(8'h40, 16'h7777);
    bus.cpu_req = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_addr = 8'h40;
    bus.host_req = 1'b1; bus.host_wr = 1'b0; bus.host_addr = 8'h05;
    for (int c = 0; c < int'(MaxWait); c++) begin
      #1;
      chk($sformatf("ct_cpu_owner%0d", c), bus.owner, 2'd0);
      chk($sformatf("ct_cpu_hold%0d", c), bus.cpu_hold, 1'b0);
      tick();
    end
    #1;
    chk("ct_issue_owner", bus.owner, 2'd1);
    chk("ct_issue_hold", bus.cpu_hold, 1'b1);
    chk("ct_issue_addr", bus.mem_addr, 8'h05);
    bus.cpu_wr = 1'b1; bus.cpu_wdata = 16'hDEAD;
    #1;
    chk("ct_issue_mem_wr", bus.mem_wr, 1'b0);
    tick(); #1;
    chk("ct_data_hold", bus.cpu_hold, 1'b1);
    chk("ct_data_mem_wr", bus.mem_wr, 1'b0);
    chk("ct_data_ack", bus.host_ack, 1'b0);
    tick(); #1;
    chk("ct_rest_owner", bus.owner, 2'd2);
    chk("ct_rest_hold", bus.cpu_hold, 1'b1);
    chk("ct_rest_addr", bus.mem_addr, 8'h40);
    chk("ct_rest_mem_wr", bus.mem_wr, 1'b0);
    chk("ct_rest_ack", bus.host_ack, 1'b1);
    chk("ct_rest_rdata", bus.host_rdata, 16'h5555);
    idle_inputs();
    tick(); #1;
    chk("ct_rel_hold", bus.cpu_hold, 1'b0);
    chk("ct_rel_owner", bus.owner, 2'd0);
    chk("ct_store_blocked", ram[8'h40], 16'h7777);
    last_rdata = 16'h5555;

    // HostReq held through the ack cycle: no re-grant, next request served
    bus.host_req = 1'b1; bus.host_wr = 1'b0; bus.host_addr = 8'h10;
    tick(); tick(); tick(); #1;
    chk("hh_ack", bus.host_ack, 1'b1);
    chk("hh_rdata", bus.host_rdata, 16'h1234);
    bus.host_addr = 8'h2A;
    tick(); #1;
    chk("hh_no_regrant", bus.owner, 2'd0);
    chk("hh_ack_low", bus.host_ack, 1'b0);
    tick(); #1;
    chk("hh_second_grant", bus.owner, 2'd1);
    tick(); tick(); #1;
    chk("hh_second_ack", bus.host_ack, 1'b1);
    chk("hh_second_rdata", bus.host_rdata, 16'hBEEF);
    idle_inputs();
    tick();

    // Reset in H_DATA drops the transaction
    bus.host_req = 1'b1; bus.host_wr = 1'b0; bus.host_addr = 8'h2A;
    tick(); tick(); #1;
    chk("rd_data_owner", bus.owner, 2'd1);
    Reset = 1'b1;
    base = ack_cnt;
    tick();
    Reset = 1'b0;
    idle_inputs();
    #1;
    chk("rd_owner", bus.owner, 2'd0);
    chk("rd_ack", bus.host_ack, 1'b0);
    chk("rd_hold", bus.cpu_hold, 1'b0);
    chk("rd_rdata", bus.host_rdata, 16'h0);
    chk("rd_ram", ram[8'h2A], 16'hBEEF);
    tick(); tick(); #1;
    chk("rd_no_ack", ack_cnt - base, 0);
    last_rdata = '0;
    tick();

    // Randomized traffic against the transaction-level model
    for (int n = 0; n < 40; n++) begin
      logic  cpu;
      logic  cwr;
      logic  hwr;
      addr_t caddr;
      addr_t haddr;
      cpu   = 1'($urandom_range(0, 1));
      cwr   = cpu & 1'($urandom_range(0, 1));
      hwr   = 1'($urandom_range(0, 1));
      caddr = addr_t'($urandom_range(0, 15));
      haddr = addr_t'($urandom_range(0, 15));
      host_xact(cpu, cwr, caddr, data_t'($urandom), hwr, haddr, data_t'($urandom));
      repeat ($urandom_range(0, 2)) tick();
    end

    mism = 0;
    for (int i = 0; i < 256; i++) begin
      if (ram[i] !== shadow[i]) mism++;
    end
    chk("ram_vs_model", mism, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
